// File: rtl/inst_fetcher_if.sv
// ---------------------------------------------------------------------------
// inst_fetcher_if
//   Bundles the instruction-cache request/response channel, the decoder-side
//   valid/ready channel and the commit flush into one interface.
//
//   master modport (used by the fetcher):
//     out: icache_req_valid, icache_req_addr[31:0]
//     in : icache_resp_valid, icache_resp_inst[31:0]
//     out: inst_valid, inst[31:0], inst_pc[31:0], inst_pred_taken
//     in : inst_ready
//     in : flush_valid, flush_pc[31:0]
//   slave modport: the mirror image, used by the cache/decoder/commit side.
// ---------------------------------------------------------------------------
interface inst_fetcher_if;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_inst;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_pred_taken;
  logic        inst_ready;
  logic        flush_valid;
  logic [31:0] flush_pc;

  modport master (
    output icache_req_valid, icache_req_addr,
    input  icache_resp_valid, icache_resp_inst,
    output inst_valid, inst, inst_pc, inst_pred_taken,
    input  inst_ready,
    input  flush_valid, flush_pc
  );

  modport slave (
    input  icache_req_valid, icache_req_addr,
    output icache_resp_valid, icache_resp_inst,
    input  inst_valid, inst, inst_pc, inst_pred_taken,
    output inst_ready,
    output flush_valid, flush_pc
  );
endinterface

// File: rtl/inst_fetcher.sv
// ---------------------------------------------------------------------------
// inst_fetcher
//   Front-end stage ahead of the decoder. Keeps the PC, issues one word fetch
//   at a time to the instruction cache, buffers each returned instruction with
//   its PC (and prediction bit) in a circular queue, and presents the queue
//   head to the decoder with a valid/ready handshake. A flush from commit
//   empties the queue and redirects the PC.
//
//   Ports:
//     clk_in  - clock, rising edge
//     rst_in  - asynchronous active-high reset
//     bus     - inst_fetcher_if.master (icache req/resp, decoder handshake,
//               flush)
//
//   Parameters:
//     QUEUE_DEPTH_LOG - log2 of queue entries
//     RESET_PC        - PC loaded on reset
//
//   Optional feature (macro STATIC_PREDICT_EN):
//     Static prediction at push time: JAL and backward conditional branches
//     redirect the fetch PC and mark the instruction as predicted taken.
//     Without the macro the PC always advances by 4 and the prediction bit
//     is 0.
// ---------------------------------------------------------------------------
module inst_fetcher #(
  parameter int          QUEUE_DEPTH_LOG = 4,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic           clk_in,
  input  logic           rst_in,
  inst_fetcher_if.master bus
);

  localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;
  localparam logic [QUEUE_DEPTH_LOG:0] DEPTH_CNT = (QUEUE_DEPTH_LOG + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t                     state, state_next;
  logic [31:0]                pc, pc_next;
  logic                       req_valid, req_valid_next;
  logic [31:0]                req_addr, req_addr_next;
  logic [QUEUE_DEPTH_LOG-1:0] head, tail;
  logic [QUEUE_DEPTH_LOG:0]   count;

  logic [31:0] q_inst [DEPTH];
  logic [31:0] q_pc   [DEPTH];
  logic        q_pred [DEPTH];

  logic        push, pop, full;
  logic [31:0] fetch_next_pc;
  logic        fetch_pred;

  assign full = (count == DEPTH_CNT);
  assign pop  = bus.inst_valid && bus.inst_ready && !bus.flush_valid;

  // PC following the instruction being returned, with optional static
  // prediction. pc still equals the outstanding request address in WAIT.
  always_comb begin
    fetch_next_pc = pc + 32'd4;
    fetch_pred    = 1'b0;
`ifdef STATIC_PREDICT_EN
    begin
      logic [31:0] j_imm;
      logic [31:0] b_imm;
      j_imm = {{12{bus.icache_resp_inst[31]}}, bus.icache_resp_inst[19:12],
               bus.icache_resp_inst[20], bus.icache_resp_inst[30:21], 1'b0};
      b_imm = {{20{bus.icache_resp_inst[31]}}, bus.icache_resp_inst[7],
               bus.icache_resp_inst[30:25], bus.icache_resp_inst[11:8], 1'b0};
      if (bus.icache_resp_inst[6:0] == 7'b1101111) begin
        fetch_next_pc = pc + j_imm;
        fetch_pred    = 1'b1;
      end else if (bus.icache_resp_inst[6:0] == 7'b1100011 &&
                   bus.icache_resp_inst[31]) begin
        fetch_next_pc = pc + b_imm;
        fetch_pred    = 1'b1;
      end
    end
`endif
  end

  // Next-state logic. A request is only issued while the queue has a free
  // slot, and nothing else pushes, so the single outstanding response always
  // has room. Flush takes priority over everything.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    req_valid_next = req_valid;
    req_addr_next  = req_addr;
    push           = 1'b0;

    case (state)
      IDLE: begin
        if (bus.flush_valid) begin
          pc_next = bus.flush_pc;
        end else if (!full) begin
          req_valid_next = 1'b1;
          req_addr_next  = pc;
          state_next     = WAIT;
        end
      end

      WAIT: begin
        if (bus.flush_valid) begin
          pc_next = bus.flush_pc;
          if (bus.icache_resp_valid) begin
            req_valid_next = 1'b0;
            state_next     = IDLE;
          end else begin
            state_next = DISCARD;
          end
        end else if (bus.icache_resp_valid) begin
          push           = 1'b1;
          pc_next        = fetch_next_pc;
          req_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      DISCARD: begin
        // The request stays visible with its old address until the stale
        // response comes back; that response retires it even if another
        // flush arrives in the same cycle.
        if (bus.flush_valid) begin
          pc_next = bus.flush_pc;
        end
        if (bus.icache_resp_valid) begin
          req_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        req_valid_next = 1'b0;
        state_next     = IDLE;
      end
    endcase
  end

  // Control state and queue pointers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_valid <= 1'b0;
      req_addr  <= 32'h0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      req_valid <= req_valid_next;
      req_addr  <= req_addr_next;
      if (bus.flush_valid) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk_in) begin
    if (push) begin
      q_inst[tail] <= bus.icache_resp_inst;
      q_pc[tail]   <= pc;
      q_pred[tail] <= fetch_pred;
    end
  end

  assign bus.icache_req_valid = req_valid;
  assign bus.icache_req_addr  = req_addr;
  assign bus.inst_valid       = (count != '0);
  assign bus.inst             = q_inst[head];
  assign bus.inst_pc          = q_pc[head];
  assign bus.inst_pred_taken  = q_pred[head];

endmodule
